lsu_data_port: RTL
==================

# lsu_data_port

Load/store initiator that drives the data port of the single-cycle computer's memory module on behalf of the core's execute stage. It accepts one byte/halfword/word load or store request at a time, performs aligned word accesses on the memory data port, extracts and sign/zero-extends load data, and implements sub-word stores as read-modify-write. It sits between the datapath and the memory module's `d_mem_*` signals.

## Interface

- `ADDR_W`, 32, byte-address width (fixed by ISA)
- `DATA_W`, 32, memory word width (fixed by ISA)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  core request present
- `req_ready`  out  1  block can accept a request
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 byte, 1 halfword, 2 word, 3 illegal
- `req_signed`  in  1  loads only: sign-extend when 1, zero-extend when 0
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  DATA_W  store data, right-justified
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_err`  out  1  misaligned/illegal request, qualified by `rsp_valid`
- `rsp_rdata`  out  DATA_W  load result, qualified by `rsp_valid`; 0 for stores/errors
- `d_mem_a`  out  ADDR_W  word-aligned address `{addr[31:2],2'b00}`
- `d_mem_read`  out  1  memory read strobe
- `d_mem_write`  out  1  memory write strobe; memory commits at the rising edge while high
- `d_mem_in_v`  out  DATA_W  memory write data
- `d_mem_out_v`  in  DATA_W  memory read data, valid the cycle after `d_mem_read`

## Operation

- States: IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, RMW_WR, WR, RESP, ERR.
- IDLE: `req_ready`=1; on `req_valid`, register write/size/signed/addr/wdata, then select:
  - size 3, half with addr[0]=1, or word with addr[1:0]!=0 -> ERR (no memory access).
  - load -> RD; word store -> WR; byte/half store -> RMW_RD.
- RD / RMW_RD: `d_mem_read`=1 one cycle. -> RD_WAIT / RMW_WAIT.
- RD_WAIT: capture `d_mem_out_v`; extract lane (byte lane = addr[1:0], half lane = addr[1], little-endian), extend per `req_signed` into `rsp_rdata`. -> RESP.
- RMW_WAIT: capture `d_mem_out_v`; replace the addressed lane with `wdata[7:0]` or `wdata[15:0]`, keep other bytes. -> RMW_WR.
- RMW_WR / WR: `d_mem_write`=1 one cycle, `d_mem_in_v` = merged word / `wdata`. -> RESP.
- RESP: `rsp_valid`=1, `rsp_err`=0. -> IDLE. ERR: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0. -> IDLE.
- `req_ready`=0 in every state but IDLE; `req_*` inputs ignored outside IDLE.
- `d_mem_read` and `d_mem_write` are never high together.
- No response backpressure: the core always accepts `rsp_valid`.

## Timing

- Cycle 0 = edge at which `req_valid && req_ready` is sampled.
- Load: `d_mem_read` cycle 1, data sampled cycle 2, `rsp_valid` cycle 3.
- Word store: `d_mem_write` cycle 1, `rsp_valid` cycle 2.
- Sub-word store: read cycle 1, sample cycle 2, write cycle 3, `rsp_valid` cycle 4.
- Error: `rsp_valid`+`rsp_err` cycle 1.
- Next request accepted at earliest the cycle after `rsp_valid`.
- `d_mem_a` and `d_mem_in_v` are stable for the entire access and hold their last values in IDLE.
- Reset: state IDLE; `req_ready`, `rsp_valid`, `rsp_err`, `d_mem_read`, `d_mem_write` = 0; `rsp_rdata`, `d_mem_a`, `d_mem_in_v` = 0. `req_ready` rises the first cycle after `rst` falls.
- Reset mid-operation: `d_mem_read`/`d_mem_write` are gated low combinationally while `rst`=1, so no partial RMW write commits. The request is dropped with no `rsp_valid`.

## Test plan

- Word store 0xDEADBEEF @0x100, then word load @0x100 -> write strobe cycle 1 with `d_mem_a`=0x100; load `rsp_rdata`=0xDEADBEEF at cycle 3.
- Memory word 0x80FF7F01 @0x200: byte loads @0x201 signed -> 0x0000007F; @0x203 signed -> 0xFFFFFF80; @0x202 unsigned -> 0x000000FF; half @0x202 signed -> 0xFFFF80FF.
- Byte store 0xAA @0x302 over 0x11223344 -> one read, one write of 0x11AA3344, `rsp_valid` cycle 4.
- Half @0x101, word @0x102, size 3 @0x100 -> each gives `rsp_err`=1 at cycle 1 with zero memory strobes.
- `req_valid` held high during a load -> `req_ready`=0 until IDLE; the second request is accepted only after `rsp_valid`.
- Assert `rst` during RMW_WR -> `d_mem_write` low that cycle, memory unchanged, no `rsp_valid`, `req_ready`=1 the cycle after `rst` falls.

Source files
------------

// File: rtl/lsu_data_port.sv
// Load/store initiator for the memory data port: aligned word accesses,
// load lane extraction with sign/zero extension, and read-modify-write sub-word stores.
module lsu_data_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] d_mem_a,
    output logic              d_mem_read,
    output logic              d_mem_write,
    output logic [DATA_W-1:0] d_mem_in_v,
    input  logic [DATA_W-1:0] d_mem_out_v
);

    typedef enum logic [3:0] {
        IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, RMW_WR, WR, RESP, ERR
    } state_t;

    state_t            state;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_q;
    logic              wr_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] in_q;

    logic              req_bad;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;
    logic [DATA_W-1:0] merged;

    assign req_bad = (req_size == 2'd3)
                  || (req_size == 2'd1 && req_addr[0])
                  || (req_size == 2'd2 && req_addr[1:0] != 2'b00);

    // NOTE: every always_comb output gets a default on entry so no path can infer a latch.
    always_comb begin
        ld_byte = d_mem_out_v[{off_q, 3'b000} +: 8];
        ld_half = d_mem_out_v[{off_q[1], 4'b0000} +: 16];
        ld_ext  = d_mem_out_v;
        merged  = d_mem_out_v;
        case (size_q)
            2'd0: begin
                ld_ext = {{(DATA_W-8){sgn_q & ld_byte[7]}}, ld_byte};
                merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'd1: begin
                ld_ext = {{(DATA_W-16){sgn_q & ld_half[15]}}, ld_half};
                merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of its peers regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            size_q      <= 2'd0;
            sgn_q       <= 1'b0;
            off_q       <= 2'd0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            a_q         <= '0;
            in_q        <= '0;
        end else begin
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (req_valid) begin
                        ready_q <= 1'b0;
                        size_q  <= req_size;
                        sgn_q   <= req_signed;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        if (req_bad) begin
                            state       <= ERR;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            a_q <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (!req_write) begin
                                state <= RD;
                                rd_q  <= 1'b1;
                            end else if (req_size == 2'd2) begin
                                state <= WR;
                                wr_q  <= 1'b1;
                                in_q  <= req_wdata;
                            end else begin
                                state <= RMW_RD;
                                rd_q  <= 1'b1;
                            end
                        end
                    end
                end
                RD:       state <= RD_WAIT;
                RMW_RD:   state <= RMW_WAIT;
                RD_WAIT: begin
                    rdata_q     <= ld_ext;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RMW_WAIT: begin
                    in_q  <= merged;
                    wr_q  <= 1'b1;
                    state <= RMW_WR;
                end
                RMW_WR, WR: begin
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP, ERR: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are masked by rst directly so a reset landing mid-RMW cannot commit a write.
    assign d_mem_read  = rd_q & ~rst;
    assign d_mem_write = wr_q & ~rst;
    assign d_mem_a     = a_q;
    assign d_mem_in_v  = in_q;
    assign req_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rdata_q;

endmodule
